fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a one-entry skid buffer.
// Holds pc and the IF/ID pipeline register. A word that hits while IF/ID
// is stalled is parked in the skid buffer so that it is neither lost nor
// fetched twice. Sticky halt freezes the stage until reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc,
  output logic        if_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    BUFFER = 2'b01,
    HALTED = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_npc_q, ifid_npc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_npc_q, skid_npc_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus4_s;

  // pc+4 wraps naturally at 2^32.
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state logic; priority is redirect > halt_in > stall > ihit.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_npc_d   = ifid_npc_q;
    ifid_valid_d = ifid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_npc_d   = skid_npc_q;
    halted_d     = halted_q;

    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d         = {redirect_pc[31:2], 2'b00};
          ifid_instr_d = 32'h0;
          ifid_npc_d   = 32'h0;
          ifid_valid_d = 1'b0;
          skid_instr_d = 32'h0;
          skid_npc_d   = 32'h0;
          state_d      = FETCH;
        end else if (halt_in && ifid_valid_q) begin
          // HALT sits in IF/ID: keep it visible and stop fetching for good.
          halted_d = 1'b1;
          state_d  = HALTED;
        end else if (stall) begin
          if (ihit) begin
            // Park the word; the fetch itself already completed.
            skid_instr_d = imemload;
            skid_npc_d   = pc_plus4_s;
            pc_d         = pc_plus4_s;
            state_d      = BUFFER;
          end else begin
            state_d = FETCH;
          end
        end else if (ihit) begin
          ifid_instr_d = imemload;
          ifid_npc_d   = pc_plus4_s;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4_s;
        end else begin
          // Miss: insert a bubble, retry the same pc.
          ifid_instr_d = 32'h0;
          ifid_npc_d   = 32'h0;
          ifid_valid_d = 1'b0;
        end
      end

      BUFFER: begin
        if (redirect) begin
          pc_d         = {redirect_pc[31:2], 2'b00};
          ifid_instr_d = 32'h0;
          ifid_npc_d   = 32'h0;
          ifid_valid_d = 1'b0;
          skid_instr_d = 32'h0;
          skid_npc_d   = 32'h0;
          state_d      = FETCH;
        end else if (halt_in && ifid_valid_q) begin
          halted_d = 1'b1;
          state_d  = HALTED;
        end else if (!stall) begin
          // Drain the parked word; pc already points past it.
          ifid_instr_d = skid_instr_q;
          ifid_npc_d   = skid_npc_q;
          ifid_valid_d = 1'b1;
          state_d      = FETCH;
        end else begin
          state_d = BUFFER;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        // Illegal encoding: fall back to a clean fetch.
        state_d = FETCH;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      ifid_instr_q <= 32'h0;
      ifid_npc_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_npc_q   <= 32'h0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_npc_q   <= ifid_npc_d;
      ifid_valid_q <= ifid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_npc_q   <= skid_npc_d;
      halted_q     <= halted_d;
    end
  end

  assign iREN     = (state_q == FETCH);
  assign imemaddr = pc_q;
  assign if_instr = ifid_instr_q;
  assign if_npc   = ifid_npc_q;
  assign if_valid = ifid_valid_q;
  assign opcode   = ifid_instr_q[31:26];
  assign funct    = ifid_instr_q[5:0];
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch stage.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_in;

  logic        iREN, if_valid, halted;
  logic [31:0] imemaddr, if_instr, if_npc;
  logic [5:0]  opcode, funct;

  logic        w_iREN, w_if_valid, w_halted;
  logic [31:0] w_imemaddr, w_if_instr, w_if_npc;
  logic [5:0]  w_opcode, w_funct;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;
  logic [63:0] pend[$];

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
    .iREN(iREN), .imemaddr(imemaddr), .if_instr(if_instr), .if_npc(if_npc),
    .if_valid(if_valid), .opcode(opcode), .funct(funct), .halted(halted)
  );

  fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dut_w (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
    .iREN(w_iREN), .imemaddr(w_imemaddr), .if_instr(w_if_instr), .if_npc(w_if_npc),
    .if_valid(w_if_valid), .opcode(w_opcode), .funct(w_funct), .halted(w_halted)
  );

  // Model: one cycle of the stage. Parked words live in a FIFO that
  // holds at most one entry; anything captured must come out exactly once.
  task automatic model_update();
    if (RST) begin
      m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0; pend.delete();
    end else if (m_halted) begin
      m_pc = m_pc;
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFFFFFC;
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; pend.delete();
    end else if (halt_in && m_valid) begin
      m_halted = 1'b1;
    end else if (stall) begin
      if (pend.size() == 0 && ihit) begin
        pend.push_back({imemload, m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
      end
    end else if (pend.size() != 0) begin
      {m_instr, m_npc} = pend.pop_front();
      m_valid = 1'b1;
    end else if (ihit) begin
      m_instr = imemload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end else begin
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    RST = 1'b0; ihit = 1'b0; imemload = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; halt_in = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (imemaddr !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want %h", imemaddr, 32'h0); end
    tests_run++; if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    tests_run++; if (if_instr !== 32'h0 || if_npc !== 32'h0) begin tests_failed++; $display("FAIL reset_ifid: got %h/%h want 0/0", if_instr, if_npc); end
    tests_run++; if (iREN !== 1'b1 || halted !== 1'b0) begin tests_failed++; $display("FAIL reset_ctl: got iREN=%b halted=%b want 1/0", iREN, halted); end
    tests_run++; if (w_imemaddr !== 32'hFFFFFFFC) begin tests_failed++; $display("FAIL reset_pcinit: got %h want %h", w_imemaddr, 32'hFFFFFFFC); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h8C010004; words[1] = 32'h00221820; words[2] = 32'hAC030008;
    do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (imemaddr !== 32'(i * 4)) begin tests_failed++; $display("FAIL seq_addr%0d: got %h want %h", i, imemaddr, 32'(i * 4)); end
      imemload = words[i];
      step();
      tests_run++; if (if_instr !== words[i] || if_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_instr%0d: got %h/%b want %h/1", i, if_instr, if_valid, words[i]); end
      tests_run++; if (if_npc !== 32'((i + 1) * 4)) begin tests_failed++; $display("FAIL seq_npc%0d: got %h want %h", i, if_npc, 32'((i + 1) * 4)); end
    end
    tests_run++; if (opcode !== 6'h2B || funct !== 6'h08) begin tests_failed++; $display("FAIL seq_decode: got %h/%h want 2b/08", opcode, funct); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    ihit = 1'b1; imemload = 32'h12345678;
    step();
    tests_run++; if (w_if_npc !== 32'h0 || w_imemaddr !== 32'h0) begin tests_failed++; $display("FAIL wrap: got npc=%h addr=%h want 0/0", w_if_npc, w_imemaddr); end
    tests_run++; if (w_if_instr !== 32'h12345678 || w_if_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_instr: got %h/%b want 12345678/1", w_if_instr, w_if_valid); end
    idle_inputs();
  endtask

  task automatic test_stall_skid();
    do_reset();
    ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imemload = 32'hA0000000 + 32'(i);
      step();
    end
    tests_run++; if (imemaddr !== 32'h10) begin tests_failed++; $display("FAIL skid_setup: got %h want 00000010", imemaddr); end
    stall = 1'b1; imemload = 32'hCAFE0010;
    step();
    tests_run++; if (if_instr !== 32'hA0000003 || if_npc !== 32'h10) begin tests_failed++; $display("FAIL skid_hold: got %h/%h want a0000003/00000010", if_instr, if_npc); end
    tests_run++; if (iREN !== 1'b0 || imemaddr !== 32'h14) begin tests_failed++; $display("FAIL skid_ctl: got iREN=%b pc=%h want 0/00000014", iREN, imemaddr); end
    imemload = 32'hDEADBEEF;
    step();
    tests_run++; if (if_instr !== 32'hA0000003 || imemaddr !== 32'h14 || iREN !== 1'b0) begin tests_failed++; $display("FAIL skid_buf_stall: got %h pc=%h iREN=%b want a0000003/00000014/0", if_instr, imemaddr, iREN); end
    stall = 1'b0; ihit = 1'b0;
    step();
    tests_run++; if (if_instr !== 32'hCAFE0010 || if_npc !== 32'h14 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_drain: got %h/%h/%b want cafe0010/00000014/1", if_instr, if_npc, if_valid); end
    tests_run++; if (iREN !== 1'b1 || imemaddr !== 32'h14) begin tests_failed++; $display("FAIL skid_resume: got iREN=%b pc=%h want 1/00000014", iREN, imemaddr); end
    idle_inputs();
  endtask

  task automatic test_redirect();
    do_reset();
    ihit = 1'b1; imemload = 32'h11111111;
    step();
    redirect = 1'b1; redirect_pc = 32'h00000103; stall = 1'b1; imemload = 32'h22222222;
    step();
    tests_run++; if (imemaddr !== 32'h100 || if_valid !== 1'b0 || if_instr !== 32'h0) begin tests_failed++; $display("FAIL redir: got pc=%h valid=%b instr=%h want 00000100/0/0", imemaddr, if_valid, if_instr); end
    tests_run++; if (iREN !== 1'b1) begin tests_failed++; $display("FAIL redir_state: got iREN=%b want 1", iREN); end
    redirect = 1'b0; stall = 1'b0; imemload = 32'h33333333;
    step();
    tests_run++; if (if_instr !== 32'h33333333 || if_npc !== 32'h104) begin tests_failed++; $display("FAIL redir_next: got %h/%h want 33333333/00000104", if_instr, if_npc); end
    // redirect while a word is parked: the parked word must vanish
    stall = 1'b1; imemload = 32'h44444444;
    step();
    redirect = 1'b1; redirect_pc = 32'h00000400;
    step();
    redirect = 1'b0; stall = 1'b0; ihit = 1'b0;
    step();
    tests_run++; if (if_valid !== 1'b0 || imemaddr !== 32'h400 || iREN !== 1'b1) begin tests_failed++; $display("FAIL redir_buf: got valid=%b pc=%h iREN=%b want 0/00000400/1", if_valid, imemaddr, iREN); end
    idle_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    halt_in = 1'b1; ihit = 1'b1; imemload = 32'hFC000000;
    step();
    tests_run++; if (halted !== 1'b0 || if_valid !== 1'b1) begin tests_failed++; $display("FAIL halt_novalid: got halted=%b valid=%b want 0/1", halted, if_valid); end
    imemload = 32'h55555555;
    step();
    tests_run++; if (halted !== 1'b1 || iREN !== 1'b0) begin tests_failed++; $display("FAIL halt_set: got halted=%b iREN=%b want 1/0", halted, iREN); end
    tests_run++; if (if_instr !== 32'hFC000000 || imemaddr !== 32'h4) begin tests_failed++; $display("FAIL halt_hold: got %h pc=%h want fc000000/00000004", if_instr, imemaddr); end
    halt_in = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    tests_run++; if (halted !== 1'b1 || iREN !== 1'b0 || imemaddr !== 32'h4 || if_instr !== 32'hFC000000) begin tests_failed++; $display("FAIL halt_sticky: got halted=%b iREN=%b pc=%h instr=%h want 1/0/00000004/fc000000", halted, iREN, imemaddr, if_instr); end
    do_reset();
    tests_run++; if (halted !== 1'b0 || imemaddr !== 32'h0 || iREN !== 1'b1 || if_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_reset: got halted=%b pc=%h iREN=%b valid=%b want 0/0/1/0", halted, imemaddr, iREN, if_valid); end
    idle_inputs();
  endtask

  task automatic test_halt_vs_redirect();
    do_reset();
    ihit = 1'b1; imemload = 32'hFC000000;
    step();
    halt_in = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000030E;
    step();
    tests_run++; if (halted !== 1'b0 || imemaddr !== 32'h30C || iREN !== 1'b1) begin tests_failed++; $display("FAIL halt_redir: got halted=%b pc=%h iREN=%b want 0/0000030c/1", halted, imemaddr, iREN); end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      RST         = ($urandom_range(0, 99) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      halt_in     = ($urandom_range(0, 39) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      ihit        = ($urandom_range(0, 2) != 0);
      imemload    = $urandom;
      step();
      tests_run++; if (imemaddr !== m_pc) begin tests_failed++; $display("FAIL rnd_pc @%0d: got %h want %h", n, imemaddr, m_pc); end
      tests_run++; if (if_instr !== m_instr || if_npc !== m_npc || if_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_ifid @%0d: got %h/%h/%b want %h/%h/%b", n, if_instr, if_npc, if_valid, m_instr, m_npc, m_valid); end
      tests_run++; if (halted !== m_halted || iREN !== (!m_halted && pend.size() == 0)) begin tests_failed++; $display("FAIL rnd_ctl @%0d: got halted=%b iREN=%b want %b/%b", n, halted, iREN, m_halted, (!m_halted && pend.size() == 0)); end
      tests_run++; if (opcode !== m_instr[31:26] || funct !== m_instr[5:0]) begin tests_failed++; $display("FAIL rnd_decode @%0d: got %h/%h want %h/%h", n, opcode, funct, m_instr[31:26], m_instr[5:0]); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    test_reset();
    test_sequential();
    test_wrap();
    test_stall_skid();
    test_redirect();
    test_halt();
    test_halt_vs_redirect();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
